// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM states and
// instruction-field width helpers.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    // Instruction layout, msb first: op(4) | rd(REG_AW) | rs(REG_AW) | imm(WIDTH)
    function automatic int instr_width(input int width, input int num_regs);
        return 4 + 2 * $clog2(num_regs) + width;
    endfunction

    function automatic int rd_lsb(input int width, input int num_regs);
        return width + $clog2(num_regs);
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: the result is formed as a WIDTH+1-bit value so the
// top bit carries the ADD carry, SUB borrow or SHL shifted-out msb.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        case (op)
            OP_ADD:  sum = {1'b0, a} + {1'b0, b};
            OP_SUB:  sum = {1'b0, a} - {1'b0, b};
            OP_AND:  sum = {1'b0, a & b};
            OP_OR:   sum = {1'b0, a | b};
            OP_XOR:  sum = {1'b0, a ^ b};
            OP_SHL:  sum = {a, 1'b0};
            default: sum = {1'b0, a};
        endcase
    end

    assign y     = sum[WIDTH-1:0];
    assign carry = sum[WIDTH];
    assign zero  = (y == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: loadable instruction memory, register file and a
// FETCH/DECODE/EXECUTE/WRITEBACK controller; every instruction takes 4 cycles.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NUM_REGS   = 4,
    parameter  int IMEM_DEPTH = 16,
    localparam int REG_AW     = $clog2(NUM_REGS),
    localparam int PC_W       = $clog2(IMEM_DEPTH),
    localparam int INSTR_W    = instr_width(WIDTH, NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               carry,
    output logic               busy,
    output logic               halted,
    output logic [PC_W-1:0]    pc,
    output logic [15:0]        retired
);

    localparam int RD_LSB = rd_lsb(WIDTH, NUM_REGS);

    state_t state, state_nxt;

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    logic [WIDTH-1:0]   regs [NUM_REGS];
    logic [INSTR_W-1:0] ir;
    logic [WIDTH-1:0]   a_q, b_q, alu_y_q;
    logic               alu_c_q, alu_z_q;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_c, alu_z;

    logic [3:0]        op;
    logic [REG_AW-1:0] rd, rs;
    logic [WIDTH-1:0]  imm;

    assign op  = ir[INSTR_W-1 -: 4];
    assign rd  = ir[RD_LSB +: REG_AW];
    assign rs  = ir[WIDTH +: REG_AW];
    assign imm = ir[WIDTH-1:0];

    assign busy   = (state inside {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK});
    assign halted = (state == S_HALT);

    cpu_alu #(.WIDTH(WIDTH)) u_alu (
        .op    (op),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .carry (alu_c),
        .zero  (alu_z)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_DECODE;
            S_DECODE:       state_nxt = S_EXECUTE;
            S_EXECUTE:      state_nxt = S_WRITEBACK;
            S_WRITEBACK:    state_nxt = (op == OP_HLT) ? S_HALT : S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the program store has no reset so it maps onto plain RAM and survives rst.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) imem[prog_addr] <= prog_data;
    end

    // NOTE: all state below uses <= so every stage sees last cycle's values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_y_q <= '0;
            alu_c_q <= 1'b0;
            alu_z_q <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            pc      <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                    end
                end
                S_FETCH: ir <= imem[pc];
                S_DECODE: begin
                    a_q <= regs[rd];
                    b_q <= regs[rs];
                end
                S_EXECUTE: begin
                    alu_y_q <= alu_y;
                    alu_c_q <= alu_c;
                    alu_z_q <= alu_z;
                end
                S_WRITEBACK: begin
                    retired <= retired + 16'd1;
                    pc      <= pc + 1'b1;
                    case (op)
                        OP_LDI: begin
                            regs[rd] <= imm;
                            result   <= imm;
                        end
                        OP_MOV: begin
                            regs[rd] <= b_q;
                            result   <= b_q;
                        end
                        OP_JMP: pc <= imm[PC_W-1:0];
                        OP_JZ:  if (zero) pc <= imm[PC_W-1:0];
                        // A halted core keeps pointing at its HLT instruction.
                        OP_HLT: pc <= pc;
                        default: begin
                            if (is_alu_op(op)) begin
                                regs[rd] <= alu_y_q;
                                result   <= alu_y_q;
                                carry    <= alu_c_q;
                                zero     <= alu_z_q;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed testbench for multicycle_cpu (default parameters: 8-bit, 4 regs, 16 words).
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        start = 1'b0;
    logic [7:0]  result;
    logic        zero, carry, busy, halted;
    logic [3:0]  pc;
    logic [15:0] retired;

    int total  = 0;
    int passed = 0;

    multicycle_cpu dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic wait_halted(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (halted) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        total++; if (result !== 8'h00 || zero !== 1'b0 || carry !== 1'b0)
            $display("FAIL reset_flags result=%h zero=%b carry=%b want 00/0/0", result, zero, carry);
        else passed++;
        total++; if (busy !== 1'b0 || halted !== 1'b0)
            $display("FAIL reset_state busy=%b halted=%b want 0/0", busy, halted);
        else passed++;
        total++; if (pc !== 4'h0 || retired !== 16'h0)
            $display("FAIL reset_counters pc=%h retired=%0d want 0/0", pc, retired);
        else passed++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        load(4'd0, mk(4'h1, 2'd0, 2'd0, 8'h01));
        load(4'd1, mk(4'h1, 2'd1, 2'd0, 8'h02));
        load(4'd2, mk(4'h3, 2'd0, 2'd1, 8'h00));
        load(4'd3, mk(4'hF, 2'd0, 2'd0, 8'h00));
        pulse_start();
        total++; if (busy !== 1'b1 || pc !== 4'h0)
            $display("FAIL basic_launch busy=%b pc=%h want 1/0", busy, pc);
        else passed++;
        repeat (15) step();
        total++; if (halted !== 1'b0)
            $display("FAIL basic_early_halt halted=%b want 0 after 15 cycles", halted);
        else passed++;
        step();
        total++; if (halted !== 1'b1 || busy !== 1'b0)
            $display("FAIL basic_halt_16 halted=%b busy=%b want 1/0", halted, busy);
        else passed++;
        total++; if (result !== 8'h03 || zero !== 1'b0 || carry !== 1'b0)
            $display("FAIL basic_result result=%h z=%b c=%b want 03/0/0", result, zero, carry);
        else passed++;
        total++; if (retired !== 16'd4)
            $display("FAIL basic_retired got %0d want 4", retired);
        else passed++;
    endtask

    task automatic test_carry();
        int n;
        load(4'd0, mk(4'h1, 2'd0, 2'd0, 8'hFF));
        load(4'd1, mk(4'h1, 2'd1, 2'd0, 8'h01));
        load(4'd2, mk(4'h3, 2'd0, 2'd1, 8'h00));
        load(4'd3, mk(4'hF, 2'd0, 2'd0, 8'h00));
        pulse_start();
        wait_halted(40, n);
        total++; if (n < 0) $display("FAIL carry_timeout halted=%b want 1", halted);
        else passed++;
        total++; if (result !== 8'h00 || zero !== 1'b1 || carry !== 1'b1)
            $display("FAIL add_wrap result=%h z=%b c=%b want 00/1/1", result, zero, carry);
        else passed++;
        // Registers survive the restart from HALT: r1=01, r0=00.
        load(4'd0, mk(4'h4, 2'd1, 2'd0, 8'h00));
        load(4'd1, mk(4'hF, 2'd0, 2'd0, 8'h00));
        pulse_start();
        wait_halted(40, n);
        total++; if (n < 0 || result !== 8'h01 || zero !== 1'b0 || carry !== 1'b0)
            $display("FAIL sub_no_borrow n=%0d result=%h z=%b c=%b want 01/0/0", n, result, zero, carry);
        else passed++;
    endtask

    task automatic test_loop();
        int n;
        load(4'd0, mk(4'h1, 2'd0, 2'd0, 8'h03));
        load(4'd1, mk(4'h1, 2'd1, 2'd0, 8'h01));
        load(4'd2, mk(4'h4, 2'd0, 2'd1, 8'h00));
        load(4'd3, mk(4'hA, 2'd0, 2'd0, 8'h05));
        load(4'd4, mk(4'h9, 2'd0, 2'd0, 8'h02));
        load(4'd5, mk(4'hF, 2'd0, 2'd0, 8'h00));
        pulse_start();
        wait_halted(100, n);
        total++; if (n < 0 || result !== 8'h00 || zero !== 1'b1)
            $display("FAIL loop_end n=%0d result=%h z=%b want 00/1", n, result, zero);
        else passed++;
        // LDI,LDI + SUB,JZ,JMP (r0=2) + SUB,JZ,JMP (r0=1) + SUB,JZ,HLT (r0=0) = 11
        total++; if (retired !== 16'd11)
            $display("FAIL loop_retired got %0d want 11", retired);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        bit wrapped, stayed_busy;
        do_reset();
        for (int i = 0; i < 15; i++) load(4'(i), mk(4'h0, 2'd0, 2'd0, 8'h00));
        load(4'd15, mk(4'h9, 2'd0, 2'd0, 8'h00));
        pulse_start();
        prev = pc;
        wrapped = 1'b0;
        stayed_busy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (busy !== 1'b1 || halted !== 1'b0) stayed_busy = 1'b0;
            if (prev == 4'd15 && pc == 4'd0) wrapped = 1'b1;
            prev = pc;
        end
        total++; if (!wrapped || !stayed_busy)
            $display("FAIL wrap_jmp wrapped=%b busy_held=%b want 1/1", wrapped, stayed_busy);
        else passed++;

        do_reset();
        load(4'd15, mk(4'h0, 2'd0, 2'd0, 8'h00));
        pulse_start();
        repeat (64) step();
        total++; if (pc !== 4'd0 || retired !== 16'd16 || busy !== 1'b1)
            $display("FAIL wrap_nop pc=%h retired=%0d busy=%b want 0/16/1", pc, retired, busy);
        else passed++;
    endtask

    task automatic test_busy_guard();
        int n;
        do_reset();
        load(4'd0, mk(4'h1, 2'd0, 2'd0, 8'h05));
        load(4'd1, mk(4'h1, 2'd1, 2'd0, 8'h07));
        load(4'd2, mk(4'h3, 2'd0, 2'd1, 8'h00));
        load(4'd3, mk(4'hF, 2'd0, 2'd0, 8'h00));
        pulse_start();
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            prog_we   = 1'b1;
            prog_addr = pc;
            prog_data = mk(4'hF, 2'd0, 2'd0, 8'h00);
            start     = (i % 3 == 0);
            step();
            if (halted) begin
                n = i;
                break;
            end
        end
        prog_we = 1'b0;
        start   = 1'b0;
        total++; if (n < 0 || result !== 8'h0C || retired !== 16'd4)
            $display("FAIL guard_run n=%0d result=%h retired=%0d want 0C/4", n, result, retired);
        else passed++;
        pulse_start();
        total++; if (busy !== 1'b1 || pc !== 4'd0 || retired !== 16'd0)
            $display("FAIL restart busy=%b pc=%h retired=%0d want 1/0/0", busy, pc, retired);
        else passed++;
        wait_halted(40, n);
        total++; if (n < 0 || result !== 8'h0C || retired !== 16'd4)
            $display("FAIL guard_imem n=%0d result=%h retired=%0d want 0C/4", n, result, retired);
        else passed++;
    endtask

    task automatic test_abort();
        int n;
        load(4'd0, mk(4'h1, 2'd0, 2'd0, 8'h01));
        load(4'd1, mk(4'h1, 2'd1, 2'd0, 8'h02));
        load(4'd2, mk(4'h3, 2'd0, 2'd1, 8'h00));
        load(4'd3, mk(4'hF, 2'd0, 2'd0, 8'h00));
        pulse_start();
        repeat (10) step();
        total++; if (pc !== 4'd2 || busy !== 1'b1 || result !== 8'h02)
            $display("FAIL abort_pre pc=%h busy=%b result=%h want 2/1/02", pc, busy, result);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (result !== 8'h00 || pc !== 4'd0 || retired !== 16'd0 || busy !== 1'b0
                     || halted !== 1'b0 || zero !== 1'b0 || carry !== 1'b0)
            $display("FAIL abort_async result=%h pc=%h retired=%0d busy=%b want all 0", result, pc, retired, busy);
        else passed++;
        #2 rst = 1'b1;
        step();
        step();
        total++; if (result !== 8'h00 || busy !== 1'b0 || halted !== 1'b0)
            $display("FAIL abort_release result=%h busy=%b halted=%b want 00/0/0", result, busy, halted);
        else passed++;
        pulse_start();
        wait_halted(40, n);
        total++; if (n < 0 || result !== 8'h03 || retired !== 16'd4)
            $display("FAIL abort_rerun n=%0d result=%h retired=%0d want 03/4", n, result, retired);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_loop();
        test_wrap();
        test_busy_guard();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
